tqvp_spi_ctrl: RTL and testbench

TQVP_SPI_CTRL -- requirements
Module: tqvp_spi_ctrl

---
 rtl/tqvp_spi_pkg.sv | 39 +++
 rtl/tqvp_spi_fifo.sv | 47 ++++
 rtl/tqvp_spi_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_tqvp_spi_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_spi_pkg.sv
// rtl/tqvp_spi_pkg.sv - shared register map, bit indices and FSM encoding for tqvp_spi_ctrl
package tqvp_spi_pkg;

   localparam logic [5:0] ADDR_DATA   = 6'h00;
   localparam logic [5:0] ADDR_STATUS = 6'h04;
   localparam logic [5:0] ADDR_CTRL   = 6'h08;
   localparam logic [5:0] ADDR_CS     = 6'h0C;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_TX_FULL   = 1;
   localparam int STAT_TX_EMPTY  = 2;
   localparam int STAT_RX_VALID  = 3;
   localparam int STAT_LEVEL_LSB = 4;
   localparam int STAT_OVERFLOW  = 7;
   localparam int STAT_IRQ_PEND  = 8;

   localparam int CTRL_DIV_LSB   = 0;
   localparam int CTRL_IRQ_EN    = 8;
   localparam int CTRL_LOOPBACK  = 10;

   localparam int FIFO_DEPTH     = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } spi_state_e;

   // Bytes actually carried by a write of the given width code (00=8, 01=16, else 32 bits)
   function automatic logic [31:0] write_mask(input logic [1:0] wr_n);
      case (wr_n)
         2'b00:   return 32'h0000_00FF;
         2'b01:   return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/tqvp_spi_fifo.sv
// rtl/tqvp_spi_fifo.sv - 4-entry x 8-bit TX FIFO with occupancy level
module tqvp_spi_fifo
   import tqvp_spi_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic [2:0] level,
   output logic       full,
   output logic       empty
);

   logic [7:0] mem [FIFO_DEPTH];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic       do_push;
   logic       do_pop;

   assign full    = (level == 3'(FIFO_DEPTH));
   assign empty   = (level == 3'd0);
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot, so a push to a full FIFO still lands
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // pointer, level and storage update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         level  <= 3'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         level <= level + {2'b00, do_push} - {2'b00, do_pop};
      end
   end

endmodule

// File: rtl/tqvp_spi_ctrl.sv
// rtl/tqvp_spi_ctrl.sv - SPI mode-0 master with register window; TQVP_SPI_LOOPBACK_EN adds CTRL[10] loopback
module tqvp_spi_ctrl
   import tqvp_spi_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   spi_state_e state, state_nx;
   logic [7:0]  div, div_act, half_cnt, shreg, rx_byte;
   logic [2:0]  bit_cnt;
   logic        sck, mosi, cs, irq_en, loopback, rx_valid, overflow, irq_pending;
   logic        wr_en, rd_en, half_end, miso;
   logic [31:0] wdata;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata;
   logic [2:0]  fifo_level;
   logic        unused_bits;

   assign wr_en     = (data_write_n != 2'b11);
   assign rd_en     = (data_read_n != 2'b11);
   assign wdata     = data_in & write_mask(data_write_n);
   assign fifo_push = wr_en && (address == ADDR_DATA);
   assign fifo_pop  = (state == S_LOAD);
   // div_act only changes at half-period boundaries, so a CTRL write never truncates a phase
   assign half_end  = (state == S_SHIFT) && (half_cnt == div_act);
   assign unused_bits = &{1'b0, ui_in[7:3], ui_in[1:0], wdata[31:9]};

`ifdef TQVP_SPI_LOOPBACK_EN
   assign miso = loopback ? mosi : ui_in[2];

   // loopback enable register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         loopback <= 1'b0;
      end else if (wr_en && (address == ADDR_CTRL)) begin
         loopback <= wdata[CTRL_LOOPBACK];
      end
   end
`else
   assign miso     = ui_in[2];
   assign loopback = 1'b0;
`endif

   tqvp_spi_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (wdata[7:0]),
      .rdata (fifo_rdata),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // FSM next state: a byte ends on the 8th falling SCK edge
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (!fifo_empty) state_nx = S_LOAD;
         S_LOAD:  state_nx = S_SHIFT;
         S_SHIFT: if (half_end && sck && (bit_cnt == 3'd7)) state_nx = S_DONE;
         S_DONE:  state_nx = fifo_empty ? S_IDLE : S_LOAD;
         default: state_nx = S_IDLE;
      endcase
   end

   // SCK generation, MISO sampling on rising edges, MOSI update on falling edges
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         half_cnt <= 8'd0;
         div_act  <= 8'd0;
         bit_cnt  <= 3'd0;
         shreg    <= 8'd0;
         sck      <= 1'b0;
         mosi     <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               shreg    <= fifo_rdata;
               mosi     <= fifo_rdata[7];
               half_cnt <= 8'd0;
               bit_cnt  <= 3'd0;
               sck      <= 1'b0;
               div_act  <= div;
            end
            S_SHIFT: begin
               if (half_end) begin
                  half_cnt <= 8'd0;
                  div_act  <= div;
                  sck      <= ~sck;
                  if (!sck) begin
                     shreg <= {shreg[6:0], miso};
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt != 3'd7) mosi <= shreg[7];
                  end
               end else begin
                  half_cnt <= half_cnt + 8'd1;
               end
            end
            default: sck <= 1'b0;
         endcase
      end
   end

   // software registers, sticky flags and receive byte
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div         <= 8'd0;
         irq_en      <= 1'b0;
         cs          <= 1'b1;
         rx_byte     <= 8'd0;
         rx_valid    <= 1'b0;
         overflow    <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         if (wr_en && (address == ADDR_CTRL)) begin
            div    <= wdata[CTRL_DIV_LSB +: 8];
            irq_en <= wdata[CTRL_IRQ_EN];
         end
         if (wr_en && (address == ADDR_CS)) cs <= wdata[0];
         if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
         else if (wr_en && (address == ADDR_STATUS) && wdata[STAT_OVERFLOW]) overflow <= 1'b0;
         if (state == S_DONE) begin
            rx_byte  <= shreg;
            rx_valid <= 1'b1;
         end else if (rd_en && (address == ADDR_DATA)) begin
            rx_valid <= 1'b0;
         end
         if ((state == S_DONE) && fifo_empty) irq_pending <= 1'b1;
         else if (wr_en && (address == ADDR_STATUS) && wdata[STAT_IRQ_PEND]) irq_pending <= 1'b0;
      end
   end

   // register read mux, unmapped addresses read zero
   always_comb begin
      data_out = 32'd0;
      case (address)
         ADDR_DATA: data_out[7:0] = rx_byte;
         ADDR_STATUS: begin
            data_out[STAT_BUSY]            = (state != S_IDLE);
            data_out[STAT_TX_FULL]         = fifo_full;
            data_out[STAT_TX_EMPTY]        = fifo_empty;
            data_out[STAT_RX_VALID]        = rx_valid;
            data_out[STAT_LEVEL_LSB +: 3]  = fifo_level;
            data_out[STAT_OVERFLOW]        = overflow;
            data_out[STAT_IRQ_PEND]        = irq_pending;
         end
         ADDR_CTRL: begin
            data_out[CTRL_DIV_LSB +: 8] = div;
            data_out[CTRL_IRQ_EN]       = irq_en;
            data_out[CTRL_LOOPBACK]     = loopback;
         end
         ADDR_CS: data_out[0] = cs;
         default: data_out = 32'd0;
      endcase
   end

   assign data_ready     = rd_en;
   assign user_interrupt = irq_pending & irq_en;
   // SCK/MOSI are forced low and CS_n high combinationally while reset is held
   assign uo_out = {2'b00, cs | ~rst_n, mosi & rst_n, sck & rst_n, 3'b000};

endmodule

// File: tb/tb_tqvp_spi_ctrl.sv
// tb/tb_tqvp_spi_ctrl.sv - randomized and directed self-checking bench for tqvp_spi_ctrl
module tb_tqvp_spi_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  ui_in = 8'h00;
   logic [7:0]  uo_out;
   logic [5:0]  address = 6'h00;
   logic [31:0] data_in = 32'h0;
   logic [1:0]  data_write_n = 2'b11;
   logic [1:0]  data_read_n = 2'b11;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;
   bit miso_fix = 1'b0;

`ifdef TQVP_SPI_LOOPBACK_EN
   localparam logic [31:0] LB_CTRL_EXP = 32'h400;
`else
   localparam logic [31:0] LB_CTRL_EXP = 32'h000;
`endif

   always #5 clk = ~clk;

   tqvp_spi_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ui_in          (ui_in),
      .uo_out         (uo_out),
      .address        (address),
      .data_in        (data_in),
      .data_write_n   (data_write_n),
      .data_read_n    (data_read_n),
      .data_out       (data_out),
      .data_ready     (data_ready),
      .user_interrupt (user_interrupt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A transfer is a run of cycles c = 0 (load), 1..16*(d+1) (shift), 16*(d+1)+1 (done).
   logic [7:0] mq[$];
   bit         m_active, m_cs, m_ovf, m_irqp, m_rxv, m_lb, m_irq_en;
   int         m_c, m_d, m_div;
   logic [7:0] m_byte, m_rxsh, m_rx;

   function automatic logic [31:0] wmask(input logic [1:0] wn);
      if (wn == 2'b00) return 32'hFF;
      if (wn == 2'b01) return 32'hFFFF;
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] model_reg(input logic [5:0] a);
      case (a)
         6'h00: return {24'h0, m_rx};
         6'h04: return {23'h0, m_irqp, m_ovf, 3'(mq.size()), m_rxv,
                        (mq.size() == 0), (mq.size() == 4), m_active};
         6'h08: return {21'h0, m_lb, 1'b0, m_irq_en, 8'(m_div)};
         6'h0C: return {31'h0, m_cs};
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) begin : model_step
      int sz0, half, pos;
      bit wr, rd, pop, done;
      logic [31:0] w;
      logic miso_m;
      wr = (data_write_n != 2'b11);
      rd = (data_read_n != 2'b11);
      w  = data_in & wmask(data_write_n);
      if (!rst_n) begin
         mq.delete();
         m_active = 0; m_c = 0; m_d = 0; m_div = 0; m_irq_en = 0; m_cs = 1;
         m_ovf = 0; m_irqp = 0; m_rxv = 0; m_lb = 0; m_rx = 0; m_rxsh = 0; m_byte = 0;
      end else begin
         sz0  = mq.size();
         pop  = m_active && (m_c == 0);
         done = m_active && (m_c == 16 * (m_d + 1) + 1);
         if (m_active && m_c >= 1 && m_c <= 16 * (m_d + 1)) begin
            half = (m_c - 1) / (m_d + 1);
            pos  = (m_c - 1) % (m_d + 1);
            if (pos == m_d && half % 2 == 0) begin
               miso_m = m_lb ? m_byte[7 - half / 2] : ui_in[2];
               m_rxsh = {m_rxsh[6:0], miso_m};
            end
         end
         if (done) begin
            m_rx = m_rxsh; m_rxv = 1;
            if (sz0 == 0) m_irqp = 1;
         end else if (rd && address == 6'h00) begin
            m_rxv = 0;
         end
         if (pop) begin
            m_byte = mq.pop_front();
            m_d = m_div;
         end
         if (wr && address == 6'h00) begin
            if (sz0 < 4 || pop) mq.push_back(w[7:0]);
            else m_ovf = 1;
         end
         if (wr && address == 6'h04) begin
            if (w[7]) m_ovf = 0;
            if (w[8] && !(done && sz0 == 0)) m_irqp = 0;
         end
         if (wr && address == 6'h08) begin
            m_div = int'(w[7:0]); m_irq_en = w[8];
`ifdef TQVP_SPI_LOOPBACK_EN
            m_lb = w[10];
`endif
         end
         if (wr && address == 6'h0C) m_cs = w[0];
         if (m_active) begin
            if (done) begin
               if (sz0 == 0) m_active = 0;
               else m_c = 0;
            end else begin
               m_c++;
            end
         end else if (sz0 > 0) begin
            m_active = 1; m_c = 0;
         end
      end
   end

   // per-cycle pin comparison against the model
   always @(negedge clk) begin
      int half;
      logic [7:0] exp_uo;
      if (cmp_en && rst_n) begin
         exp_uo = 8'h00;
         exp_uo[5] = m_cs;
         if (m_active && m_c >= 1 && m_c <= 16 * (m_d + 1)) begin
            half = (m_c - 1) / (m_d + 1);
            exp_uo[3] = (half % 2 == 1);
            exp_uo[4] = m_byte[7 - half / 2];
            check("uo_out_shift", uo_out, exp_uo);
         end else begin
            check("uo_out_idle", uo_out & 8'hEF, exp_uo);
         end
         check("user_interrupt", user_interrupt, m_irqp & m_irq_en);
      end
   end

   // pin monitors: bytes seen on MOSI at SCK rising edges, SCK high-phase lengths
   logic [7:0] cap_bits = 8'h00;
   int         cap_n = 0;
   logic [7:0] cap_q[$];
   int         hi_n = 0, run = 0, max_run = 0;

   always @(posedge uo_out[3]) begin
      cap_bits = {cap_bits[6:0], uo_out[4]};
      cap_n++;
      if (cap_n % 8 == 0) cap_q.push_back(cap_bits);
   end

   always @(negedge clk) begin
      if (uo_out[3]) begin
         hi_n++; run++;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
   end

   always @(posedge clk) begin
      #2;
      ui_in = miso_fix ? 8'h04 : 8'($urandom);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wr_w(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
      address = a; data_in = d; data_write_n = wn; data_read_n = 2'b11;
      tick();
      data_write_n = 2'b11;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      wr_w(a, d, 2'b10);
   endtask

   task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
      address = a; data_read_n = 2'($urandom_range(0, 2));
      #1;
      check({name, "_ready"}, data_ready, 1'b1);
      check(name, data_out, exp);
      tick();
      data_read_n = 2'b11;
   endtask

   task automatic poll_idle(input int budget, output int busy_n);
      logic [31:0] v;
      busy_n = 0;
      for (int i = 0; i < budget; i++) begin
         address = 6'h04; data_read_n = 2'b10;
         #1;
         check("poll_status", data_out, model_reg(6'h04));
         v = data_out;
         if (v[0]) busy_n++;
         tick();
         data_read_n = 2'b11;
         if (!v[0] && v[2]) return;
      end
      errors++; checks++;
      $display("FAIL poll_idle: timeout after %0d cycles, required idle", budget);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required $finish");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin : main
      int busy_n, k;
      logic [7:0] r, b [5];

      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // reset values
      check("rst_uo_out", uo_out, 8'h20);
      check("rst_irq", user_interrupt, 1'b0);
      rd_chk("rst_status", 6'h04, 32'h004);
      rd_chk("rst_ctrl", 6'h08, 32'h000);
      rd_chk("rst_cs", 6'h0C, 32'h001);
      rd_chk("rst_data", 6'h00, 32'h000);

      // div=0, MISO high, byte 0xA5
      miso_fix = 1'b1;
      cap_q.delete(); cap_n = 0;
      wr(6'h0C, 32'h0);
      wr(6'h00, 32'hA5);
      poll_idle(100, busy_n);
      check("a5_busy_cycles", busy_n, 18);
      check("a5_nbytes", cap_q.size(), 1);
      if (cap_q.size() > 0) check("a5_mosi", cap_q[0], 8'hA5);
      rd_chk("a5_rx", 6'h00, 32'hFF);
      miso_fix = 1'b0;

      // div=3: 4-clock phases, 8 rising edges
      wr(6'h04, 32'h180);
      wr(6'h08, 32'h003);
      r = 8'($urandom);
      cap_q.delete(); cap_n = 0; hi_n = 0; max_run = 0;
      wr(6'h00, {24'h0, r});
      poll_idle(200, busy_n);
      check("div3_busy_cycles", busy_n, 66);
      check("div3_rises", cap_n, 8);
      check("div3_high_clocks", hi_n, 32);
      check("div3_max_high_run", max_run, 4);
      if (cap_q.size() > 0) check("div3_mosi", cap_q[0], r);
      rd_chk("div3_rx", 6'h00, model_reg(6'h00));

      // interrupt only after the second of two queued bytes
      wr(6'h04, 32'h180);
      wr(6'h08, 32'h100);
      wr(6'h00, 32'h11);
      wr(6'h00, 32'h22);
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (user_interrupt) begin k = i; break; end
      end
      check("irq_latency", k, 36);
      check("irq_high", user_interrupt, 1'b1);
      wr(6'h04, 32'h100);
      check("irq_cleared", user_interrupt, 1'b0);
      poll_idle(50, busy_n);

      // five back-to-back writes then a sixth into a full FIFO
      wr(6'h08, 32'h000);
      rd_chk("b2b_pre_rx", 6'h00, model_reg(6'h00));
      cap_q.delete(); cap_n = 0;
      for (int i = 0; i < 5; i++) begin
         b[i] = 8'($urandom);
         wr(6'h00, {24'h0, b[i]});
      end
      rd_chk("b2b_status_full", 6'h04, 32'h043);
      wr(6'h00, 32'hEE);
      rd_chk("b2b_status_ovf", 6'h04, 32'h0C3);
      poll_idle(200, busy_n);
      check("b2b_nbytes", cap_q.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < cap_q.size()) check("b2b_order", cap_q[i], b[i]);
      wr(6'h04, 32'h080);
      rd_chk("b2b_ovf_w1c", 6'h04, model_reg(6'h04));

      // loopback
      wr(6'h08, 32'h400);
      rd_chk("lb_ctrl", 6'h08, LB_CTRL_EXP);
      wr(6'h00, 32'h3C);
      poll_idle(100, busy_n);
`ifdef TQVP_SPI_LOOPBACK_EN
      rd_chk("lb_rx", 6'h00, 32'h3C);
`else
      rd_chk("lb_rx", 6'h00, model_reg(6'h00));
`endif
      wr(6'h08, 32'h000);

      // reset during bit 4 of a byte
      wr(6'h04, 32'h180);
      wr(6'h08, 32'h100);
      cap_n = 0;
      wr(6'h00, 32'h5A);
      for (int i = 0; i < 100 && cap_n < 5; i++) tick();
      check("rst_mid_reached_bit4", cap_n, 5);
      rst_n = 1'b0;
      #1;
      check("rst_mid_sck_low", uo_out[3], 1'b0);
      tick();
      rst_n = 1'b1;
      rd_chk("rst_mid_status", 6'h04, 32'h004);
      check("rst_mid_irq", user_interrupt, 1'b0);
      for (int i = 0; i < 40; i++) tick();
      check("rst_mid_no_irq_later", user_interrupt, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 9))
            0, 1: wr_w(6'h00, $urandom, 2'($urandom_range(0, 2)));
            2: rd_chk("rnd_status", 6'h04, model_reg(6'h04));
            3: rd_chk("rnd_data", 6'h00, model_reg(6'h00));
            4: wr_w(6'h04, $urandom & 32'h180, 2'($urandom_range(0, 2)));
            5: if (!m_active && mq.size() == 0)
                  wr(6'h08, {$urandom, 8'($urandom_range(0, 2))} & 32'h5FF);
               else tick();
            6: rd_chk("rnd_ctrl", 6'h08, model_reg(6'h08));
            7: begin
                  automatic logic [5:0] a = ($urandom_range(0, 1) == 0) ? 6'h0C : 6'($urandom_range(16, 63));
                  rd_chk("rnd_misc", a, model_reg(a));
               end
            8: if ($urandom_range(0, 1) == 0) wr(6'h0C, $urandom & 32'h1);
               else wr(6'($urandom_range(16, 63)), $urandom);
            default: tick();
         endcase
      end
      poll_idle(2000, busy_n);
      rd_chk("final_status", 6'h04, model_reg(6'h04));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
